// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-address type used by the writeback stage.
package cpu_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;
  localparam int LINK_REG   = 31;
  localparam int REG_ZERO   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/writeback_regfile_wb_select.sv
// Combinational writeback select: picks the value, the destination and the effective write enable.
import cpu_pkg::*;

module wb_select #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int LINK_REG = cpu_pkg::LINK_REG
) (
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_result,
  input  reg_addr_t         wb_reg_address,
  input  logic              wb_jump_reg,
  input  logic              wb_link,
  input  logic              wb_link_to_rd,
  input  logic [DATA_W-1:0] wb_pc_plus8,
  output logic [DATA_W-1:0] wr_value,
  output reg_addr_t         wr_dest,
  output logic              wr_en
);

  // Link has priority over the load/ALU choice.
  always_comb begin
    if (wb_link) begin
      wr_value = wb_pc_plus8;
    end else if (wb_mem_to_reg) begin
      wr_value = wb_data;
    end else begin
      wr_value = wb_result;
    end
  end

  assign wr_dest = (wb_link && !wb_link_to_rd) ? reg_addr_t'(LINK_REG) : wb_reg_address;

  // jr always suppresses the write, even when a link marker rides along.
  assign wr_en = (wb_reg_write | wb_link) & ~wb_jump_reg
               & (wr_dest != reg_addr_t'(REG_ZERO));

endmodule

// File: rtl/writeback_regfile.sv
// MEM/WB consumer: selects the writeback value, commits it to the register file and serves two
// bypassed read ports. Optional debug read port and last-destination tracker: REGFILE_DEBUG_PORT_EN.
import cpu_pkg::*;

module writeback_regfile #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NREGS    = cpu_pkg::NREGS,
  parameter int LINK_REG = cpu_pkg::LINK_REG
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_result,
  input  reg_addr_t         wb_reg_address,
  input  logic              wb_jump_reg,
  input  logic              wb_link,
  input  logic              wb_link_to_rd,
  input  logic [DATA_W-1:0] wb_pc_plus8,
  input  reg_addr_t         rd_addr_a,
  input  reg_addr_t         rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
`ifdef REGFILE_DEBUG_PORT_EN
  input  reg_addr_t         dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output reg_addr_t         dbg_last_dest,
`endif
  output logic [31:0]       commit_count
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wr_value;
  reg_addr_t         wr_dest;
  logic              wr_en;
  logic              bypass_en;

  wb_select #(
    .DATA_W   (DATA_W),
    .LINK_REG (LINK_REG)
  ) u_wb_select (
    .wb_reg_write   (wb_reg_write),
    .wb_mem_to_reg  (wb_mem_to_reg),
    .wb_data        (wb_data),
    .wb_result      (wb_result),
    .wb_reg_address (wb_reg_address),
    .wb_jump_reg    (wb_jump_reg),
    .wb_link        (wb_link),
    .wb_link_to_rd  (wb_link_to_rd),
    .wb_pc_plus8    (wb_pc_plus8),
    .wr_value       (wr_value),
    .wr_dest        (wr_dest),
    .wr_en          (wr_en)
  );

  // A write presented during reset is dropped, so it must not be forwarded either.
  assign bypass_en = reset_n & wr_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      commit_count <= '0;
    end else if (wr_en) begin
      regs[wr_dest] <= wr_value;
      commit_count  <= commit_count + 32'd1;
    end
  end

  always_comb begin
    if (rd_addr_a == reg_addr_t'(REG_ZERO)) begin
      rd_data_a = '0;
    end else if (bypass_en && (rd_addr_a == wr_dest)) begin
      rd_data_a = wr_value;
    end else begin
      rd_data_a = regs[rd_addr_a];
    end
  end

  always_comb begin
    if (rd_addr_b == reg_addr_t'(REG_ZERO)) begin
      rd_data_b = '0;
    end else if (bypass_en && (rd_addr_b == wr_dest)) begin
      rd_data_b = wr_value;
    end else begin
      rd_data_b = regs[rd_addr_b];
    end
  end

`ifdef REGFILE_DEBUG_PORT_EN
  // Storage-only view: never shows the in-flight write.
  assign dbg_data = (dbg_addr == reg_addr_t'(REG_ZERO)) ? '0 : regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dbg_last_dest <= '0;
    end else if (wr_en) begin
      dbg_last_dest <= wr_dest;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized bench for writeback_regfile against an array-based architectural model.
module tb_writeback_regfile;

  logic        clk;
  logic        reset_n;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [31:0] wb_data;
  logic [31:0] wb_result;
  logic [4:0]  wb_reg_address;
  logic        wb_jump_reg;
  logic        wb_link;
  logic        wb_link_to_rd;
  logic [31:0] wb_pc_plus8;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [31:0] commit_count;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [4:0]  dbg_last_dest;
  logic [4:0]  model_last_dest;
`endif

  writeback_regfile dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wb_reg_write   (wb_reg_write),
    .wb_mem_to_reg  (wb_mem_to_reg),
    .wb_data        (wb_data),
    .wb_result      (wb_result),
    .wb_reg_address (wb_reg_address),
    .wb_jump_reg    (wb_jump_reg),
    .wb_link        (wb_link),
    .wb_link_to_rd  (wb_link_to_rd),
    .wb_pc_plus8    (wb_pc_plus8),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .rd_data_a      (rd_data_a),
    .rd_data_b      (rd_data_b),
`ifdef REGFILE_DEBUG_PORT_EN
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data),
    .dbg_last_dest  (dbg_last_dest),
`endif
    .commit_count   (commit_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          rw;
    bit          m2r;
    bit          jr;
    bit          link;
    bit          l2rd;
    logic [31:0] data;
    logic [31:0] result;
    logic [31:0] pc8;
    logic [4:0]  addr;
    logic [4:0]  ra;
    logic [4:0]  rb;
  } stim_t;

  // ---------------- reference model ----------------
  logic [31:0] model_regs [32];
  logic [31:0] model_count;
  bit          model_valid;
  int          errors;
  int          checks;

  function automatic logic [31:0] m_value(stim_t s);
    if (s.link) return s.pc8;
    if (s.m2r)  return s.data;
    return s.result;
  endfunction

  function automatic logic [4:0] m_dest(stim_t s);
    return (s.link && !s.l2rd) ? 5'd31 : s.addr;
  endfunction

  function automatic bit m_we(stim_t s);
    return (s.rw || s.link) && !s.jr && (m_dest(s) != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a, stim_t s);
    if (a == 5'd0) return 32'd0;
    if (s.rst_n && m_we(s) && a == m_dest(s)) return m_value(s);
    return model_regs[a];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input stim_t s, input string tag);
    @(negedge clk);
    reset_n        = s.rst_n;
    wb_reg_write   = s.rw;
    wb_mem_to_reg  = s.m2r;
    wb_jump_reg    = s.jr;
    wb_link        = s.link;
    wb_link_to_rd  = s.l2rd;
    wb_data        = s.data;
    wb_result      = s.result;
    wb_pc_plus8    = s.pc8;
    wb_reg_address = s.addr;
    rd_addr_a      = s.ra;
    rd_addr_b      = s.rb;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr       = 5'($urandom_range(0, 31));
`endif
    #1;
    if (model_valid) begin
      check({tag, ".rd_a"}, rd_data_a, m_read(s.ra, s));
      check({tag, ".rd_b"}, rd_data_b, m_read(s.rb, s));
`ifdef REGFILE_DEBUG_PORT_EN
      check({tag, ".dbg"}, dbg_data, (dbg_addr == 5'd0) ? 32'd0 : model_regs[dbg_addr]);
`endif
    end
    @(posedge clk);
    if (!s.rst_n) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
      model_valid = 1'b1;
`ifdef REGFILE_DEBUG_PORT_EN
      model_last_dest = 5'd0;
`endif
    end else if (m_we(s)) begin
      model_regs[m_dest(s)] = m_value(s);
      model_count = model_count + 32'd1;
`ifdef REGFILE_DEBUG_PORT_EN
      model_last_dest = m_dest(s);
`endif
    end
    #1;
    if (model_valid) begin
      check({tag, ".count"}, commit_count, model_count);
`ifdef REGFILE_DEBUG_PORT_EN
      check({tag, ".last_dest"}, {27'd0, dbg_last_dest}, {27'd0, model_last_dest});
`endif
    end
  endtask

  function automatic stim_t idle(logic [4:0] ra, logic [4:0] rb);
    stim_t s;
    s.rst_n = 1'b1; s.rw = 1'b0; s.m2r = 1'b0; s.jr = 1'b0; s.link = 1'b0; s.l2rd = 1'b0;
    s.data = 32'd0; s.result = 32'd0; s.pc8 = 32'd0; s.addr = 5'd0;
    s.ra = ra; s.rb = rb;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [4:0] pool [4];
    pool[0] = 5'd0; pool[1] = 5'd4; pool[2] = 5'd8; pool[3] = 5'd31;
    s.rst_n  = ($urandom_range(0, 49) != 0);
    s.rw     = 1'($urandom_range(0, 1));
    s.m2r    = 1'($urandom_range(0, 1));
    s.jr     = ($urandom_range(0, 5) == 0);
    s.link   = ($urandom_range(0, 3) == 0);
    s.l2rd   = 1'($urandom_range(0, 1));
    s.data   = $urandom;
    s.result = $urandom;
    s.pc8    = $urandom;
    s.addr   = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : 5'($urandom_range(0, 31));
    s.ra     = $urandom_range(0, 1) ? m_dest(s) : 5'($urandom_range(0, 31));
    s.rb     = $urandom_range(0, 1) ? m_dest(s) : 5'($urandom_range(0, 31));
    return s;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    errors = 0;
    checks = 0;
    model_valid = 1'b0;
    model_count = 32'd0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
`ifdef REGFILE_DEBUG_PORT_EN
    model_last_dest = 5'd0;
`endif

    s = idle(5'd5, 5'd0); s.rst_n = 1'b0;
    apply(s, "reset");
    apply(idle(5'd5, 5'd0), "after_reset");

    s = idle(5'd8, 5'd8); s.rw = 1'b1; s.result = 32'h1234; s.addr = 5'd8;
    apply(s, "alu_bypass");
    apply(idle(5'd8, 5'd0), "alu_stored");

    s = idle(5'd9, 5'd8); s.rw = 1'b1; s.m2r = 1'b1; s.data = 32'hDEADBEEF; s.result = 32'h1; s.addr = 5'd9;
    apply(s, "load_bypass");
    apply(idle(5'd9, 5'd8), "load_stored");

    s = idle(5'd0, 5'd0); s.rw = 1'b1; s.result = 32'hFFFF; s.addr = 5'd0;
    apply(s, "zero_guard");
    apply(idle(5'd0, 5'd9), "zero_after");

    s = idle(5'd31, 5'd5); s.link = 1'b1; s.pc8 = 32'h400008; s.addr = 5'd5;
    apply(s, "jal");
    apply(idle(5'd31, 5'd5), "jal_stored");

    s = idle(5'd4, 5'd4); s.rw = 1'b1; s.result = 32'hAA; s.addr = 5'd4;
    apply(s, "pre_jr");
    s = idle(5'd4, 5'd4); s.rw = 1'b1; s.jr = 1'b1; s.result = 32'h77; s.addr = 5'd4;
    apply(s, "jr_suppress");
    apply(idle(5'd4, 5'd4), "jr_after");

    s = idle(5'd6, 5'd31); s.jr = 1'b1; s.link = 1'b1; s.l2rd = 1'b1; s.pc8 = 32'h1111; s.addr = 5'd6;
    apply(s, "jr_link");
    s = idle(5'd7, 5'd31); s.link = 1'b1; s.m2r = 1'b1; s.l2rd = 1'b1; s.data = 32'hBAD; s.pc8 = 32'h1000; s.addr = 5'd7;
    apply(s, "link_over_load");
    apply(idle(5'd7, 5'd6), "link_over_load_stored");

    s = idle(5'd10, 5'd10); s.rw = 1'b1; s.result = 32'h55; s.addr = 5'd10; s.rst_n = 1'b0;
    apply(s, "reset_mid_write");
    apply(idle(5'd10, 5'd31), "reset_mid_after");

    for (int n = 0; n < 500; n++) begin
      apply(rand_stim(), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
